ptt_rx: RTL
===========

Name: ptt_rx

Overview:
- Upstream front end for ptt2e: receives 2741-style start-stop serial PTT characters from the typewriter line.
- Checks parity and framing, and strips upshift/downshift codes while tracking the case state.
- Presents a 6-bit keyboard code plus case flag through a valid/ready handshake.
- Output is sized to drive ptt2e i_keyboard / i_lower_upper_case directly.

Parameters:
- CLKS_PER_BIT, 8, i_clk cycles per serial bit; even, >=4.
- UPSHIFT_CODE, 6'o34, PTT code that selects upper case; consumed, not emitted.
- DOWNSHIFT_CODE, 6'o37, PTT code that selects lower case; consumed, not emitted.
- DROP_NULL, 1, when 1 a received code 6'o00 is discarded silently.

Ports:
- i_clk  in  1  system clock.
- i_reset  in  1  synchronous, active-low reset (0 = reset), sampled on rising i_clk.
- i_rxd  in  1  asynchronous serial line; idle = 1 (mark).
- i_ready  in  1  downstream accepts character when high with o_valid.
- o_keyboard  out  6  received PTT code.
- o_lower_upper_case  out  1  case at time of character; 1 = lower, 0 = upper.
- o_valid  out  1  o_keyboard/o_lower_upper_case hold a character.
- o_case  out  1  current sticky case state.
- o_parity_err  out  1  one-cycle pulse, bad parity.
- o_frame_err  out  1  one-cycle pulse, stop bit sampled 0.
- o_overrun  out  1  one-cycle pulse, good character lost because holding register full.

Behaviour:
- Frame format: start bit (0), 6 data bits LSB first, check bit, stop bit (1).
- Parity is odd over the 6 data bits plus the check bit.
- i_rxd passes through a 2-flop synchronizer; all decisions use the synchronized value rxs.
- Reset (i_reset=0): state=IDLE, o_valid=0, o_keyboard=0, o_lower_upper_case=1, o_case=1, all error pulses 0, counters 0.
- Reset mid-frame aborts the frame with no output.
- FSM transitions:
  - IDLE: rxs==0 -> START, bit counter=0.
  - START: after CLKS_PER_BIT/2 cycles, sample rxs. If 1 (glitch), return to IDLE with no error. If 0, go to DATA.
  - DATA: sample every CLKS_PER_BIT cycles; shift into bit 0..5. After the 6th sample -> PARITY.
  - PARITY: sample one bit after CLKS_PER_BIT cycles -> STOP.
  - STOP: sample after CLKS_PER_BIT cycles. If 1 -> IDLE (frame done). If 0 -> o_frame_err pulse -> WAIT_MARK.
  - WAIT_MARK: stay until rxs==1, then -> IDLE. A held-low break produces exactly one o_frame_err.
- Frame completion is evaluated in the cycle after the stop sample (cycle C+1), in this priority order:
  - Parity bad: o_parity_err=1 in C+1; frame discarded, including shift codes.
  - Code==UPSHIFT_CODE: o_case<=0 in C+1; nothing emitted.
  - Code==DOWNSHIFT_CODE: o_case<=1 in C+1; nothing emitted.
  - Code==0 and DROP_NULL: discarded silently.
  - Otherwise, holding register empty (or i_ready&&o_valid this cycle): o_keyboard<=code, o_lower_upper_case<=o_case, o_valid<=1 in C+1.
  - Otherwise (holding register full): character dropped, o_overrun=1 in C+1, held data unchanged.
- Handshake: the transfer occurs in a cycle with o_valid&&i_ready. o_valid deasserts next cycle unless reloaded the same cycle. o_keyboard and o_lower_upper_case remain stable while o_valid=1 and !i_ready.
- A case change never alters an already-held character's o_lower_upper_case.
- Error pulses are exactly one cycle; multiple error types cannot occur in the same frame except frame_err, which is checked before parity. With stop=0 only o_frame_err fires.
- Back-to-back frames (stop bit immediately followed by the next start) must be received without loss.

Test Plan:
- CLKS_PER_BIT=8, i_ready=1; send code 6'o61, check 0 -> o_valid one cycle with o_keyboard=6'o61, o_lower_upper_case=1, no error pulses.
- Send 6'o34 (check 0), then 6'o61 -> exactly one o_valid, o_keyboard=6'o61, o_lower_upper_case=0, o_case=0. Then send 6'o37 and 6'o22 -> 6'o22 with case=1.
- Send 6'o61 with check bit 1 -> o_parity_err single pulse, no o_valid. Send 6'o34 with bad parity -> o_case stays 1.
- Hold i_rxd low 3 cycles, then high -> no output, no errors (false start). Send frame 6'o61 with stop=0, line low 40 cycles -> exactly one o_frame_err; next good frame 6'o12 received correctly.
- i_ready=0; send 6'o41 then 6'o42 -> o_valid held with 6'o41, o_overrun pulse on second. Raise i_ready -> one transfer of 6'o41, then o_valid=0.
- Assert i_reset=0 at the 3rd data bit of a frame, release, send 6'o65 -> o_valid with 6'o65 only, o_case=1.

Source files
------------

// File: rtl/ptt_rx.sv
// Purpose: 2741-style start-stop serial PTT receiver with parity/framing checks and shift-code tracking.
// Latency: a character appears on o_valid one cycle after its stop bit is sampled (mid stop bit).
// Backpressure: one holding register; a good character arriving while it is full is dropped with o_overrun.
//
// Ports:
//   i_clk, i_reset           clock; synchronous active-low reset
//   i_rxd                    raw serial line, idle mark = 1
//   i_ready                  downstream accept, transfer on o_valid && i_ready
//   o_keyboard               6-bit PTT code of the held character
//   o_lower_upper_case       case at time of reception (1 = lower)
//   o_valid                  holding register occupied
//   o_case                   sticky current case (1 = lower)
//   o_parity_err             one-cycle pulse, odd parity failed
//   o_frame_err              one-cycle pulse, stop bit sampled low
//   o_overrun                one-cycle pulse, good character lost to a full holding register
module ptt_rx #(
  parameter int         CLKS_PER_BIT   = 8,
  parameter logic [5:0] UPSHIFT_CODE   = 6'o34,
  parameter logic [5:0] DOWNSHIFT_CODE = 6'o37,
  parameter bit         DROP_NULL      = 1'b1
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_rxd,
  input  logic       i_ready,
  output logic [5:0] o_keyboard,
  output logic       o_lower_upper_case,
  output logic       o_valid,
  output logic       o_case,
  output logic       o_parity_err,
  output logic       o_frame_err,
  output logic       o_overrun
);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT_MARK} state_t;

  localparam int            CW        = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_LAST = CW'(CLKS_PER_BIT - 1);

  state_t        state;
  logic          rx_meta;
  logic          rxs;
  logic [CW-1:0] clk_cnt;
  logic [2:0]    bit_cnt;
  logic [5:0]    shreg;
  logic          chk_bit;

  logic hold_free;
  logic parity_ok;
  logic tick;

  // The holding register can take a new character if empty or being drained this cycle.
  assign hold_free = !o_valid || i_ready;
  assign parity_ok = ^{shreg, chk_bit};
  assign tick      = (clk_cnt == FULL_LAST);

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      state              <= IDLE;
      rx_meta            <= 1'b1;
      rxs                <= 1'b1;
      clk_cnt            <= '0;
      bit_cnt            <= '0;
      shreg              <= '0;
      chk_bit            <= 1'b0;
      o_keyboard         <= '0;
      o_lower_upper_case <= 1'b1;
      o_valid            <= 1'b0;
      o_case             <= 1'b1;
      o_parity_err       <= 1'b0;
      o_frame_err        <= 1'b0;
      o_overrun          <= 1'b0;
    end else begin
      rx_meta      <= i_rxd;
      rxs          <= rx_meta;
      o_parity_err <= 1'b0;
      o_frame_err  <= 1'b0;
      o_overrun    <= 1'b0;

      // Drain first; a frame completing in the same cycle may reload below.
      if (o_valid && i_ready) o_valid <= 1'b0;

      case (state)
        IDLE: begin
          if (!rxs) begin
            state   <= START;
            clk_cnt <= '0;
            bit_cnt <= '0;
          end
        end

        START: begin
          // Re-check the start bit at its middle; a high line here was a glitch.
          if (clk_cnt == HALF_LAST) begin
            clk_cnt <= '0;
            state   <= rxs ? IDLE : DATA;
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end

        DATA: begin
          if (tick) begin
            clk_cnt <= '0;
            shreg   <= {rxs, shreg[5:1]};  // LSB arrives first
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == 3'd5) state <= PARITY;
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end

        PARITY: begin
          if (tick) begin
            clk_cnt <= '0;
            chk_bit <= rxs;
            state   <= STOP;
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end

        STOP: begin
          if (tick) begin
            clk_cnt <= '0;
            if (!rxs) begin
              // Framing is judged before parity; a bad stop discards everything.
              o_frame_err <= 1'b1;
              state       <= WAIT_MARK;
            end else begin
              state <= IDLE;
              if (!parity_ok) begin
                o_parity_err <= 1'b1;
              end else if (shreg == UPSHIFT_CODE) begin
                o_case <= 1'b0;
              end else if (shreg == DOWNSHIFT_CODE) begin
                o_case <= 1'b1;
              end else if (DROP_NULL && (shreg == 6'o00)) begin
                // null code discarded
              end else if (hold_free) begin
                o_keyboard         <= shreg;
                o_lower_upper_case <= o_case;
                o_valid            <= 1'b1;
              end else begin
                o_overrun <= 1'b1;
              end
            end
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end

        WAIT_MARK: begin
          // A held break yields a single frame error; wait for mark before re-arming.
          if (rxs) state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
